// File: rtl/pc_seq_ctrl_if.sv
// Fetch-sequencer bus: redirect/hold requests in, fetch address and status out.
// The trap request exists only when PC_TRAP_EN is defined.
interface pc_seq_ctrl_if #(
    parameter int WIDTH_I = 32
);
`ifdef PC_TRAP_EN
    logic               trap;
`endif
    logic               stall;
    logic               br_taken;
    logic [WIDTH_I-1:0] br_target;
    logic               jmp;
    logic [WIDTH_I-1:0] jmp_target;
    logic [WIDTH_I-1:0] pc_addr;
    logic               if_valid;
    logic               flush;
    logic               misalign;

    modport master (
`ifdef PC_TRAP_EN
        output trap,
`endif
        output stall,
        output br_taken,
        output br_target,
        output jmp,
        output jmp_target,
        input  pc_addr,
        input  if_valid,
        input  flush,
        input  misalign
    );

    modport slave (
`ifdef PC_TRAP_EN
        input  trap,
`endif
        input  stall,
        input  br_taken,
        input  br_target,
        input  jmp,
        input  jmp_target,
        output pc_addr,
        output if_valid,
        output flush,
        output misalign
    );
endinterface

// File: rtl/pc_seq_ctrl.sv
// Program-counter sequencer: BOOT/RUN/STALL/REDIRECT FSM with fully registered outputs.
// Optional trap vectoring (highest priority, TRAP_ADDR parameter) is enabled by PC_TRAP_EN.
module pc_seq_ctrl #(
    parameter int                 WIDTH_I    = 32,
    parameter logic [WIDTH_I-1:0] RESET_ADDR = WIDTH_I'(32'h0000_0000)
`ifdef PC_TRAP_EN
    ,
    parameter logic [WIDTH_I-1:0] TRAP_ADDR  = WIDTH_I'(32'h0000_0080)
`endif
) (
    input logic           clk,
    input logic           rst_n,
    pc_seq_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        BOOT     = 2'd0,
        RUN      = 2'd1,
        STALL    = 2'd2,
        REDIRECT = 2'd3
    } state_t;

    function automatic logic [WIDTH_I-1:0] align_tgt(input logic [WIDTH_I-1:0] t);
        return {t[WIDTH_I-1:2], 2'b00};
    endfunction

    function automatic logic is_misaligned(input logic [WIDTH_I-1:0] t);
        return |t[1:0];
    endfunction

    state_t             state_p0, nxt_state;
    logic [WIDTH_I-1:0] pc_p0, nxt_pc;
    logic               vld_p0, nxt_vld;
    logic               flush_p0, nxt_flush;
    logic               mis_p0, nxt_mis;

    logic               redir_take;
    logic [WIDTH_I-1:0] redir_tgt;

    // Select the single winning redirect; losing targets never reach misalign.
    always_comb begin
        redir_take = 1'b0;
        redir_tgt  = '0;
`ifdef PC_TRAP_EN
        if (bus.trap) begin
            redir_take = 1'b1;
            redir_tgt  = TRAP_ADDR;
        end else
`endif
        if (bus.br_taken) begin
            redir_take = 1'b1;
            redir_tgt  = bus.br_target;
        end else if (bus.jmp) begin
            redir_take = 1'b1;
            redir_tgt  = bus.jmp_target;
        end
    end

    always_comb begin
        nxt_state = state_p0;
        nxt_pc    = pc_p0;
        nxt_vld   = 1'b0;
        nxt_flush = 1'b0;
        nxt_mis   = 1'b0;
        case (state_p0)
            BOOT: begin
                nxt_state = RUN;
                nxt_pc    = RESET_ADDR;
                nxt_vld   = 1'b1;
            end
            default: begin
                // RUN, STALL and REDIRECT share the same event handling.
                if (redir_take) begin
                    nxt_state = REDIRECT;
                    nxt_pc    = align_tgt(redir_tgt);
                    nxt_flush = 1'b1;
                    nxt_mis   = is_misaligned(redir_tgt);
                end else if (bus.stall) begin
                    nxt_state = STALL;
                    nxt_vld   = 1'b1;
                end else begin
                    nxt_state = RUN;
                    nxt_pc    = pc_p0 + WIDTH_I'(4);
                    nxt_vld   = 1'b1;
                end
            end
        endcase
    end

    // p0: architectural PC, FSM state and registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_p0 <= BOOT;
            pc_p0    <= RESET_ADDR;
            vld_p0   <= 1'b0;
            flush_p0 <= 1'b0;
            mis_p0   <= 1'b0;
        end else begin
            state_p0 <= nxt_state;
            pc_p0    <= nxt_pc;
            vld_p0   <= nxt_vld;
            flush_p0 <= nxt_flush;
            mis_p0   <= nxt_mis;
        end
    end

    assign bus.pc_addr  = pc_p0;
    assign bus.if_valid = vld_p0;
    assign bus.flush    = flush_p0;
    assign bus.misalign = mis_p0;

endmodule

// File: doc/pc_seq_ctrl.md
PC_SEQ_CTRL -- requirements
Module: pc_seq_ctrl

Interface
REQ-001 SHALL have parameter WIDTH_I, default 32, meaning PC/address width in bits.
REQ-002 SHALL have parameter RESET_ADDR, default 32'h0000_0000, meaning first fetch address after reset.
REQ-003 SHALL have parameter TRAP_ADDR, default 32'h0000_0080, meaning trap vector address (used only with PC_TRAP_EN).
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 stall  input  1  hazard-unit hold request; PC frozen while high.
REQ-007 br_taken  input  1  branch resolved taken this cycle.
REQ-008 br_target  input  WIDTH_I  branch target address.
REQ-009 jmp  input  1  unconditional jump this cycle.
REQ-010 jmp_target  input  WIDTH_I  jump target address.
REQ-011 trap  input  1  exception request (present only with PC_TRAP_EN).
REQ-012 pc_addr  output  WIDTH_I  current fetch address, registered.
REQ-013 if_valid  output  1  fetch at pc_addr is valid this cycle.
REQ-014 flush  output  1  kill instruction in IF/ID, registered one-cycle pulse.
REQ-015 misalign  output  1  registered one-cycle pulse: accepted redirect target had nonzero bits [1:0].

Function
REQ-016 SHALL implement states BOOT, RUN, STALL, REDIRECT in a registered FSM.
REQ-017 BOOT: entered on reset; pc_addr=RESET_ADDR, if_valid=0; unconditionally goes to RUN next cycle; inputs ignored in BOOT.
REQ-018 RUN: if_valid=1; with no event, pc_addr <= pc_addr+4 each cycle (sequential increment internal to this block).
REQ-019 Increment SHALL be modulo 2^WIDTH_I: pc_addr 32'hFFFF_FFFC -> 32'h0000_0000, no flag.
REQ-020 Event priority SHALL be trap > br_taken > jmp > stall > sequential increment; only highest active event acts.
REQ-021 Redirect (br_taken or jmp, or trap): pc_addr <= target with bits [1:0] forced to 0 on next edge; state -> REDIRECT; flush=1 and if_valid=0 for exactly that one cycle.
REQ-022 misalign SHALL pulse in the same cycle as flush when the accepted target bits [1:0] != 0; ignored losing targets SHALL NOT set misalign.
REQ-023 REDIRECT: lasts one cycle; next state RUN, or STALL if stall high; redirect input during REDIRECT SHALL be accepted (back-to-back redirect, REDIRECT again).
REQ-024 stall high in RUN (no redirect): pc_addr held, state -> STALL; if_valid=1 (same fetch replayed), flush=0.
REQ-025 STALL: pc_addr held while stall=1; stall low -> RUN, increment resumes next cycle; redirect during STALL overrides stall (REQ-021).
REQ-026 Simultaneous br_taken and jmp: br_target SHALL win.
REQ-027 No output SHALL be combinationally dependent on inputs; latency from event to new pc_addr is exactly 1 clock.

Reset
REQ-028 rst_n low SHALL immediately, regardless of clk, force state=BOOT, pc_addr=RESET_ADDR, if_valid=0, flush=0, misalign=0.
REQ-029 Reset asserted mid-operation (any state, pending redirect) SHALL discard all pending events; release restarts from BOOT.

Configuration
REQ-030 Macro PC_TRAP_EN: when defined, port trap exists and trap redirects pc_addr to TRAP_ADDR with highest priority per REQ-020/021.
REQ-031 Without PC_TRAP_EN, port trap and TRAP_ADDR logic SHALL be absent; priority becomes br_taken > jmp > stall > increment.

Verification
REQ-032 Reset release, no events -> pc_addr 0x0 (BOOT, if_valid=0), then 0x0, 0x4, 0x8 with if_valid=1.
REQ-033 In RUN at 0x10, br_taken=1, br_target=0x200, jmp=1, jmp_target=0x300 one cycle -> next pc_addr 0x200, flush=1, if_valid=0, then 0x204.
REQ-034 At 0x20, stall high 3 cycles -> pc_addr stays 0x20 3 cycles, flush=0; stall low -> 0x24; stall+jmp to 0x41 -> pc_addr 0x40, misalign=1, flush=1.
REQ-035 Force pc to 0xFFFF_FFF8 via jmp, run 2 cycles -> 0xFFFF_FFFC, 0x0000_0000.
REQ-036 With PC_TRAP_EN, trap with br_taken (target 0x500) -> pc_addr 0x80, flush=1; rst_n low mid-REDIRECT -> pc_addr 0x0, flush=0 immediately.
